// File: rtl/itof_pkg.sv
// itof_pkg: shared constants and types for the integer-to-binary32 converter.
//   FP32_BIAS / FP32_EXP_W / FP32_MAN_W : binary32 field geometry
//   rm_e                                : per-operand rounding mode encoding
// The stage structs depend on the operand and tag widths, so they are declared
// inside itof_pipe using its own localparams.
package itof_pkg;

  localparam int FP32_BIAS  = 127;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  typedef enum logic {
    RM_RNE = 1'b0,  // round to nearest, ties to even
    RM_RTZ = 1'b1   // round toward zero (truncate)
  } rm_e;

endpackage

// File: rtl/itof_lzc.sv
// itof_lzc: combinational leading-zero counter.
//   data  : W-bit value to scan from the MSB
//   count : number of leading zeros; an all-zero input returns W
module itof_lzc #(
  parameter  int W  = 32,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data,
  output logic [CW-1:0] count
);

  // Ascending scan: the highest set bit is the last to write, so it wins.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/itof_pipe.sv
// itof_pipe: three-stage elastic integer -> IEEE-754 binary32 converter.
//   clk, rstn            : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake
//   in_data/in_signed    : IW-bit integer, 1 = two's complement, 0 = unsigned
//   in_rm                : 0 = nearest-even, 1 = toward zero (per operand)
//   in_tag               : opaque TW-bit tag returned with the result
//   out_valid/out_ready  : result handshake
//   out_data/out_inexact : binary32 result and "rounded" flag
//   out_tag              : tag of the result
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its payload stable until the transfer;
// ready may depend combinationally on the consumer's ready, never on valid.
//
// Stages: S1 absolute value, S2 normalise, S3 round and pack (S3 regs are the
// outputs). A stage loads when it is empty or its contents move on, so bubbles
// collapse and up to three results are held under backpressure.
module itof_pipe
  import itof_pkg::*;
#(
  parameter int IW = 32,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  input  logic          in_signed,
  input  logic          in_rm,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_inexact,
  output logic [TW-1:0] out_tag
);

  localparam int LZW = $clog2(IW + 1);
  // Normalised bits below the hidden one, followed by zero padding so the
  // 23-bit fraction, guard bit and at least one sticky bit always exist.
  localparam int XW  = IW - 1 + FP32_MAN_W + 2;

  if (IW < 8 || IW > 64) begin : g_bad_iw
    $error("itof_pipe: IW=%0d outside legal range 8..64", IW);
  end
  if (TW < 1 || TW > 16) begin : g_bad_tw
    $error("itof_pipe: TW=%0d outside legal range 1..16", TW);
  end

  typedef struct packed {
    logic          sign;
    logic          zero;
    rm_e           rm;
    logic [TW-1:0] tag;
    logic [IW-1:0] mag;
  } s1_t;

  typedef struct packed {
    logic                  sign;
    logic                  zero;
    rm_e                   rm;
    logic [TW-1:0]         tag;
    logic [FP32_EXP_W-1:0] e;     // unbiased exponent, 0..IW-1
    logic [IW-1:0]         norm;
  } s2_t;

  // ---------------- flow control ----------------
  logic v1, v2;
  logic ld1, ld2, ld3;

  assign ld3      = !out_valid || out_ready;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign in_ready = ld1;

  // ---------------- S1: absolute value ----------------
  logic          in_sign;
  logic [IW-1:0] in_mag;
  s1_t           s1;

  assign in_sign = in_signed & in_data[IW-1];
  // The signed minimum negates to itself, which read as unsigned is 2^(IW-1).
  assign in_mag  = in_sign ? -in_data : in_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    v1 <= 1'b0;
    else if (ld1) v1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (in_valid && ld1) begin
      s1 <= '{sign: in_sign, zero: (in_mag == '0), rm: rm_e'(in_rm),
              tag: in_tag, mag: in_mag};
    end
  end

  // ---------------- S2: normalise ----------------
  logic [LZW-1:0] lz;
  s2_t            s2;

  itof_lzc #(.W(IW)) u_lzc (
    .data  (s1.mag),
    .count (lz)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    v2 <= 1'b0;
    else if (ld2) v2 <= v1;
  end

  always_ff @(posedge clk) begin
    if (v1 && ld2) begin
      s2 <= '{sign: s1.sign, zero: s1.zero, rm: s1.rm, tag: s1.tag,
              e: FP32_EXP_W'(IW - 1) - FP32_EXP_W'(lz),
              norm: s1.mag << lz};
    end
  end

  // ---------------- S3: round and pack ----------------
  logic [XW-1:0]         ext;
  logic [FP32_MAN_W-1:0] frac;
  logic                  guard, sticky, inc, carry;
  logic [FP32_MAN_W:0]   sum;
  logic [FP32_EXP_W-1:0] bexp;
  logic [31:0]           res;
  logic                  inexact;

  assign ext    = {s2.norm[IW-2:0], {(FP32_MAN_W + 2){1'b0}}};
  assign frac   = ext[XW-1 -: FP32_MAN_W];
  assign guard  = ext[XW-1-FP32_MAN_W];
  assign sticky = |ext[XW-2-FP32_MAN_W:0];
  assign inc    = (s2.rm == RM_RNE) & guard & (sticky | frac[0]);
  assign sum    = {1'b0, frac} + {{FP32_MAN_W{1'b0}}, inc};
  // A carry only happens from an all-ones fraction, leaving sum[22:0] zero.
  assign carry  = sum[FP32_MAN_W];
  assign bexp   = s2.e + FP32_EXP_W'(FP32_BIAS) + FP32_EXP_W'(carry);
  assign res    = s2.zero ? 32'h0000_0000 : {s2.sign, bexp, sum[FP32_MAN_W-1:0]};
  assign inexact = !s2.zero & (guard | sticky);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_inexact <= 1'b0;
      out_tag     <= '0;
    end else if (ld3) begin
      out_valid <= v2;
      if (v2) begin
        out_data    <= res;
        out_inexact <= inexact;
        out_tag     <= s2.tag;
      end
    end
  end

endmodule

// File: tb/tb_itof_pipe.sv
// tb_itof_pipe: directed + random bench for itof_pipe at IW=32, with smaller
// directed runs on IW=8 and IW=64 instances.
module tb_itof_pipe;

  localparam int W = 37;  // {tag[3:0], inexact, data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rstn;

  // ---------------- IW=32 instance ----------------
  logic        in_valid, in_ready, in_signed, in_rm;
  logic [31:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready, out_inexact;
  logic [31:0] out_data;
  logic [3:0]  out_tag;

  itof_pipe #(.IW(32), .TW(4)) u_dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_signed(in_signed), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_inexact(out_inexact), .out_tag(out_tag)
  );

  // ---------------- IW=8 instance ----------------
  logic       i8_valid, i8_ready, i8_signed, i8_rm;
  logic [7:0] i8_data;
  logic [3:0] i8_tag;
  logic       o8_valid, o8_inexact;
  logic [31:0] o8_data;
  logic [3:0] o8_tag;

  itof_pipe #(.IW(8), .TW(4)) u_dut8 (
    .clk(clk), .rstn(rstn),
    .in_valid(i8_valid), .in_ready(i8_ready), .in_data(i8_data),
    .in_signed(i8_signed), .in_rm(i8_rm), .in_tag(i8_tag),
    .out_valid(o8_valid), .out_ready(1'b1), .out_data(o8_data),
    .out_inexact(o8_inexact), .out_tag(o8_tag)
  );

  // ---------------- IW=64 instance ----------------
  logic        i64_valid, i64_ready, i64_signed, i64_rm;
  logic [63:0] i64_data;
  logic [3:0]  i64_tag;
  logic        o64_valid, o64_inexact;
  logic [31:0] o64_data;
  logic [3:0]  o64_tag;

  itof_pipe #(.IW(64), .TW(4)) u_dut64 (
    .clk(clk), .rstn(rstn),
    .in_valid(i64_valid), .in_ready(i64_ready), .in_data(i64_data),
    .in_signed(i64_signed), .in_rm(i64_rm), .in_tag(i64_tag),
    .out_valid(o64_valid), .out_ready(1'b1), .out_data(o64_data),
    .out_inexact(o64_inexact), .out_tag(o64_tag)
  );

  // ---------------- scoreboard state ----------------
  int             checks = 0;
  int             failures = 0;
  logic [W-1:0]   exp_q[$];
  int             acc_q[$];
  logic           lat_chk = 1'b0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference: exact magnitude, locate MSB, round the dropped remainder.
  // Returns {inexact, binary32}.
  function automatic logic [32:0] ref_conv(input logic [63:0] d, input int w,
                                           input logic sg, input logic rm);
    logic [64:0] m, keep, rem, half;
    logic        s;
    int          p, sh;
    m = 65'(d);
    if (w < 64) m = m & ((65'd1 << w) - 65'd1);
    s = sg & m[w-1];
    if (s) m = (65'd1 << w) - m;
    if (m == 65'd0) return 33'd0;
    p = 0;
    for (int i = 0; i < 65; i++) if (m[i]) p = i;
    if (p <= 23) begin
      keep = m << (23 - p);
      return {1'b0, s, 8'(p + 127), keep[22:0]};
    end
    sh   = p - 23;
    keep = m >> sh;
    rem  = m & ((65'd1 << sh) - 65'd1);
    half = 65'd1 << (sh - 1);
    if (!rm && (rem > half || (rem == half && keep[0]))) keep = keep + 65'd1;
    if (keep[24]) begin
      keep = keep >> 1;
      p++;
    end
    return {(rem != 65'd0), s, 8'(p + 127), keep[22:0]};
  endfunction

  // ---------------- driver tasks (IW=32) ----------------
  task automatic send32(input logic [31:0] d, input logic sg, input logic rm,
                        input logic [3:0] tg, input logic [32:0] exp);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_signed = sg; in_rm = rm; in_tag = tg;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("accept_timeout", 64'(in_ready), 64'd1);
    exp_q.push_back({tg, exp});
    acc_q.push_back(cyc);
  endtask

  task automatic drain32();
    int n;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk); n++;
    end
    #2;
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] held;
    logic [W-1:0] obs;
    logic [W-1:0] e;
    logic         held_v;
    int           a;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rstn) begin
        obs = {out_tag, out_inexact, out_data};
        if (held_v) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_stable", 64'(obs), 64'(held));
        end
        held_v = out_valid && !out_ready;
        held   = obs;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 64'(obs), 64'(0));
            check("unexpected_valid", 64'(out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("result", 64'(obs), 64'(e));
            if (lat_chk) check("latency", 64'(cyc - a), 64'd3);
          end
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // ---------------- IW=8 / IW=64 directed runs ----------------
  task automatic run8(input string name, input logic [7:0] d, input logic sg,
                      input logic rm, input logic [32:0] exp);
    int n;
    @(negedge clk);
    i8_valid = 1'b1; i8_data = d; i8_signed = sg; i8_rm = rm; i8_tag = 4'h5;
    @(negedge clk);
    i8_valid = 1'b0;
    #1;
    n = 0;
    while (!o8_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check(name, {27'd0, o8_tag, o8_inexact, o8_data}, {27'd0, 4'h5, exp});
  endtask

  task automatic run64(input string name, input logic [63:0] d, input logic sg,
                       input logic rm, input logic [32:0] exp);
    int n;
    @(negedge clk);
    i64_valid = 1'b1; i64_data = d; i64_signed = sg; i64_rm = rm; i64_tag = 4'hA;
    @(negedge clk);
    i64_valid = 1'b0;
    #1;
    n = 0;
    while (!o64_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check(name, {27'd0, o64_tag, o64_inexact, o64_data}, {27'd0, 4'hA, exp});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    logic [63:0] d64;
    logic        sg, rm;
    logic [3:0]  tg;
    int          acc;

    rstn = 1'b0;
    in_valid = 1'b0; in_data = '0; in_signed = 1'b0; in_rm = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    i8_valid = 1'b0; i8_data = '0; i8_signed = 1'b0; i8_rm = 1'b0; i8_tag = '0;
    i64_valid = 1'b0; i64_data = '0; i64_signed = 1'b0; i64_rm = 1'b0; i64_tag = '0;

    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_inexact", 64'(out_inexact), 64'd0);
    check("reset_out_tag", 64'(out_tag), 64'd0);
    check("reset_o8_valid", 64'(o8_valid), 64'd0);
    check("reset_o64_valid", 64'(o64_valid), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("in_ready_after_reset", 64'(in_ready), 64'd1);

    // Basic values and extremes at IW=32.
    send32(32'h0000_0001, 1'b1, 1'b0, 4'h1, {1'b0, 32'h3F80_0000});
    send32(32'hFFFF_FFFF, 1'b1, 1'b0, 4'h2, {1'b0, 32'hBF80_0000});
    send32(32'h0000_0000, 1'b1, 1'b0, 4'h3, {1'b0, 32'h0000_0000});
    send32(32'h8000_0000, 1'b1, 1'b0, 4'h4, {1'b0, 32'hCF00_0000});
    send32(32'h8000_0000, 1'b0, 1'b0, 4'h5, {1'b0, 32'h4F00_0000});
    send32(32'hFFFF_FFFF, 1'b0, 1'b0, 4'h6, {1'b1, 32'h4F80_0000});
    send32(32'hFFFF_FFFF, 1'b0, 1'b1, 4'h7, {1'b1, 32'h4F7F_FFFF});
    // Rounding boundaries.
    send32(32'h0100_0001, 1'b0, 1'b0, 4'h8, {1'b1, 32'h4B80_0000});
    send32(32'h0100_0001, 1'b0, 1'b1, 4'h9, {1'b1, 32'h4B80_0000});
    send32(32'h0100_0003, 1'b0, 1'b0, 4'hA, {1'b1, 32'h4B80_0002});
    send32(32'h0100_0003, 1'b0, 1'b1, 4'hB, {1'b1, 32'h4B80_0001});
    send32(32'h00FF_FFFF, 1'b0, 1'b0, 4'hC, {1'b0, 32'h4B7F_FFFF});
    drain32();

    // 100 back-to-back random operands with mixed modes and tags.
    lat_chk = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d  = $urandom;
      if ($urandom_range(0, 3) == 0) d = d >> $urandom_range(0, 31);
      sg = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      tg = 4'($urandom_range(0, 15));
      send32(d, sg, rm, tg, ref_conv(64'(d), 32, sg, rm));
    end
    drain32();
    lat_chk = 1'b0;

    // Backpressure: out_ready low for 10 cycles with a continuous producer.
    acc = 0;
    d   = $urandom;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = d; in_signed = 1'b1; in_rm = 1'(acc);
      in_tag = 4'(acc);
      #1;
      if (in_ready) begin
        exp_q.push_back({4'(acc), ref_conv(64'(d), 32, 1'b1, 1'(acc))});
        acc_q.push_back(cyc);
        acc++;
        d = $urandom;
      end
    end
    check("bp_accepted", 64'(acc), 64'd3);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    drain32();

    // Reset with two operands in flight.
    send32(32'd5, 1'b0, 1'b0, 4'h1, ref_conv(64'd5, 32, 1'b0, 1'b0));
    send32(32'd7, 1'b0, 1'b1, 4'h2, ref_conv(64'd7, 32, 1'b0, 1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("rst_pre_valid", 64'(out_valid), 64'd1);
    rstn = 1'b0;
    #1;
    check("rst_async_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check("rst_no_stale", 64'(out_valid), 64'd0);
    send32(32'hFFFF_FFFE, 1'b1, 1'b0, 4'hE, {1'b0, 32'hC000_0000});
    drain32();

    // IW=8.
    run8("iw8_min_signed", 8'h80, 1'b1, 1'b0, {1'b0, 32'hC300_0000});
    run8("iw8_one", 8'h01, 1'b1, 1'b0, {1'b0, 32'h3F80_0000});
    run8("iw8_ff_unsigned", 8'hFF, 1'b0, 1'b0, {1'b0, 32'h437F_0000});
    run8("iw8_ff_signed", 8'hFF, 1'b1, 1'b1, {1'b0, 32'hBF80_0000});
    run8("iw8_zero", 8'h00, 1'b1, 1'b0, {1'b0, 32'h0000_0000});

    // IW=64.
    run64("iw64_ones_rne", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, {1'b1, 32'h5F80_0000});
    run64("iw64_ones_rtz", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, {1'b1, 32'h5F7F_FFFF});
    run64("iw64_min_signed", 64'h8000_0000_0000_0000, 1'b1, 1'b0, {1'b0, 32'hDF00_0000});
    run64("iw64_neg_one", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, {1'b0, 32'hBF80_0000});
    for (int i = 0; i < 8; i++) begin
      d64 = {$urandom, $urandom} >> $urandom_range(0, 40);
      sg  = 1'($urandom_range(0, 1));
      rm  = 1'($urandom_range(0, 1));
      run64("iw64_random", d64, sg, rm, ref_conv(d64, 64, sg, rm));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
